// File: rtl/sd_arbiter_if.sv
// ---------------------------------------------------------------------------
// sd_arbiter_if
//   IO-block side of the SD-card emulation channel, shared between
//   sd_arbiter (master) and the MiST IO block (slave).
//
//   sd_lba          master->slave  32  sector address
//   sd_rd, sd_wr    master->slave   2  per-drive read/write request bits
//   sd_ack          slave->master   1  high while the sector is serviced
//   sd_dout_strobe  slave->master   1  buffer byte IO->core valid
//   sd_din_strobe   slave->master   1  core must present the write byte
//   sd_din          master->slave   8  write byte from the granted client
// ---------------------------------------------------------------------------
interface sd_arbiter_if;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd;
  logic [1:0]  sd_wr;
  logic        sd_ack;
  logic        sd_dout_strobe;
  logic        sd_din_strobe;
  logic [7:0]  sd_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_din,
    input  sd_ack, sd_dout_strobe, sd_din_strobe
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_din,
    output sd_ack, sd_dout_strobe, sd_din_strobe
  );
endinterface

// File: rtl/sd_arbiter.sv
// ---------------------------------------------------------------------------
// sd_arbiter
//   Shares the single SD-card emulation channel of the IO block between two
//   sector clients (0 = ACSI hard disk, 1 = floppy). One-cycle read/write
//   requests are latched per client, granted round-robin and issued one
//   sector at a time over the sd_rd/sd_wr/sd_ack handshake. Buffer strobes
//   and write data are routed only to/from the granted client.
//
//   Ports
//     clk_sys, reset          clock, synchronous active-high reset
//     cN_rd, cN_wr            one-cycle request pulses (read wins a tie)
//     cN_lba, cN_drive        sector address / drive, sampled with the pulse
//     cN_busy                 request pending or in service
//     cN_done, cN_err         completion pulse, err = aborted by timeout
//     cN_dout_strobe          IO->core byte valid for client N
//     cN_din_strobe, cN_din   core->IO byte request / byte from client N
//     sd                      IO-block side (sd_arbiter_if.master)
//
//   Build option: define SD_ARB_TIMEOUT_EN to abort a request that stays
//   outstanding for TIMEOUT_CYCLES clk_sys cycles. Without it the FSM waits
//   indefinitely and cN_err is always 0.
// ---------------------------------------------------------------------------
module sd_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
  input  logic         clk_sys,
  input  logic         reset,

  input  logic         c0_rd,
  input  logic         c0_wr,
  input  logic [31:0]  c0_lba,
  input  logic         c0_drive,
  output logic         c0_busy,
  output logic         c0_done,
  output logic         c0_err,
  output logic         c0_dout_strobe,
  output logic         c0_din_strobe,
  input  logic [7:0]   c0_din,

  input  logic         c1_rd,
  input  logic         c1_wr,
  input  logic [31:0]  c1_lba,
  input  logic         c1_drive,
  output logic         c1_busy,
  output logic         c1_done,
  output logic         c1_err,
  output logic         c1_dout_strobe,
  output logic         c1_din_strobe,
  input  logic [7:0]   c1_din,

  sd_arbiter_if.master sd
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  pend_q;
  logic [31:0] lba_q [2];
  logic [1:0]  drive_q;
  logic [1:0]  wr_q;
  logic        last_g_q;
  logic        grant_q;
  logic [31:0] sd_lba_q;
  logic        g_drive_q;
  logic        g_wr_q;

  logic        active;
  logic [1:0]  busy;
  logic [1:0]  take;
  logic        grant_fire;
  logic        pick;
  logic        tmo_hit;
  logic        idle_ok;
  logic        err_q;

  assign active  = (state_q == ISSUE) || (state_q == XFER);
  assign busy[0] = pend_q[0] | ((grant_q == 1'b0) && (state_q != IDLE));
  assign busy[1] = pend_q[1] | ((grant_q == 1'b1) && (state_q != IDLE));
  // A pulse from a client that is already pending or in service is dropped.
  assign take[0] = (c0_rd | c0_wr) & ~busy[0];
  assign take[1] = (c1_rd | c1_wr) & ~busy[1];

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    pick       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((|pend_q) && idle_ok) begin
          grant_fire = 1'b1;
          // Tie goes to the client that was not served last.
          pick       = (&pend_q) ? ~last_g_q : pend_q[1];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (tmo_hit)        state_d = DONE;
        else if (sd.sd_ack) state_d = XFER;
      end
      XFER: begin
        if (tmo_hit || !sd.sd_ack) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_q    <= 2'b00;
      last_g_q  <= 1'b1;
      grant_q   <= 1'b0;
      sd_lba_q  <= 32'd0;
      g_drive_q <= 1'b0;
      g_wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 2; i++) begin
        if (take[i]) pend_q[i] <= 1'b1;
      end
      if (grant_fire) begin
        grant_q   <= pick;
        sd_lba_q  <= lba_q[pick];
        g_drive_q <= drive_q[pick];
        g_wr_q    <= wr_q[pick];
      end
      if (state_q == DONE) begin
        pend_q[grant_q] <= 1'b0;
        last_g_q        <= grant_q;
      end
    end
  end

  // NOTE: the per-client request latches have no reset; they are only read
  // while the matching pending flag is set, which reset does clear.
  always_ff @(posedge clk_sys) begin
    if (take[0]) begin
      lba_q[0]   <= c0_lba;
      drive_q[0] <= c0_drive;
      wr_q[0]    <= c0_wr & ~c0_rd;
    end
    if (take[1]) begin
      lba_q[1]   <= c1_lba;
      drive_q[1] <= c1_drive;
      wr_q[1]    <= c1_wr & ~c1_rd;
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt_q;

  assign tmo_hit = active && (tmo_cnt_q == (TIMEOUT_CYCLES - 24'd1));
  // After an abort the IO block may still hold sd_ack; let it settle first.
  assign idle_ok = ~sd.sd_ack;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tmo_cnt_q <= 24'd0;
      err_q     <= 1'b0;
    end else begin
      if (grant_fire)  tmo_cnt_q <= 24'd0;
      else if (active) tmo_cnt_q <= tmo_cnt_q + 24'd1;
      if (active && (state_d == DONE)) err_q <= tmo_hit;
    end
  end
`else
  logic unused_timeout_cfg;

  assign tmo_hit            = 1'b0;
  assign idle_ok            = 1'b1;
  assign err_q              = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // IO-block handshake: request bits only while waiting for the ack.
  assign sd.sd_lba = sd_lba_q;
  assign sd.sd_rd  = (state_q == ISSUE && !g_wr_q) ? (2'b01 << g_drive_q) : 2'b00;
  assign sd.sd_wr  = (state_q == ISSUE &&  g_wr_q) ? (2'b01 << g_drive_q) : 2'b00;
  // Routing already in ISSUE: the IO block fetches write byte 0 on the sd_wr edge.
  assign sd.sd_din = active ? (grant_q ? c1_din : c0_din) : 8'h00;

  assign c0_busy        = busy[0];
  assign c1_busy        = busy[1];
  assign c0_done        = (state_q == DONE) && !grant_q;
  assign c1_done        = (state_q == DONE) &&  grant_q;
  assign c0_err         = c0_done & err_q;
  assign c1_err         = c1_done & err_q;
  assign c0_dout_strobe = active && !grant_q && sd.sd_dout_strobe;
  assign c1_dout_strobe = active &&  grant_q && sd.sd_dout_strobe;
  assign c0_din_strobe  = active && !grant_q && sd.sd_din_strobe;
  assign c1_din_strobe  = active &&  grant_q && sd.sd_din_strobe;

endmodule

// File: tb/tb_sd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sd_arbiter
//   Directed bench for sd_arbiter: reset state, single read, tie-breaking in
//   both directions, dout/din routing, reset during a transfer and (with
//   SD_ARB_TIMEOUT_EN) the timeout abort. Inputs change 1 ns after a rising
//   edge; outputs are sampled at the same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_sd_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;

  logic        c0_rd = 1'b0, c0_wr = 1'b0, c0_drive = 1'b0;
  logic [31:0] c0_lba = 32'd0;
  logic [7:0]  c0_din = 8'd0;
  logic        c0_busy, c0_done, c0_err, c0_dout_strobe, c0_din_strobe;

  logic        c1_rd = 1'b0, c1_wr = 1'b0, c1_drive = 1'b0;
  logic [31:0] c1_lba = 32'd0;
  logic [7:0]  c1_din = 8'd0;
  logic        c1_busy, c1_done, c1_err, c1_dout_strobe, c1_din_strobe;

  int passed = 0;
  int total  = 0;
  int c0_dout_cnt = 0;
  int c1_dout_cnt = 0;

  sd_arbiter_if bus ();

  sd_arbiter #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .c0_rd          (c0_rd),
    .c0_wr          (c0_wr),
    .c0_lba         (c0_lba),
    .c0_drive       (c0_drive),
    .c0_busy        (c0_busy),
    .c0_done        (c0_done),
    .c0_err         (c0_err),
    .c0_dout_strobe (c0_dout_strobe),
    .c0_din_strobe  (c0_din_strobe),
    .c0_din         (c0_din),
    .c1_rd          (c1_rd),
    .c1_wr          (c1_wr),
    .c1_lba         (c1_lba),
    .c1_drive       (c1_drive),
    .c1_busy        (c1_busy),
    .c1_done        (c1_done),
    .c1_err         (c1_err),
    .c1_dout_strobe (c1_dout_strobe),
    .c1_din_strobe  (c1_din_strobe),
    .c1_din         (c1_din),
    .sd             (bus.master)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (c0_dout_strobe) c0_dout_cnt <= c0_dout_cnt + 1;
    if (c1_dout_strobe) c1_dout_cnt <= c1_dout_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    bus.sd_ack         = 1'b0;
    bus.sd_dout_strobe = 1'b0;
    bus.sd_din_strobe  = 1'b0;

    // ---- reset state ----
    tick(); tick();
    reset = 1'b0;
    check("rst_sd_rd",  bus.sd_rd,  2'b00);
    check("rst_sd_wr",  bus.sd_wr,  2'b00);
    check("rst_sd_lba", bus.sd_lba, 32'd0);
    check("rst_busy",   {c1_busy, c0_busy}, 2'b00);
    check("rst_done",   {c1_done, c0_done, c1_err, c0_err}, 4'b0000);
    check("rst_sd_din", bus.sd_din, 8'h00);

    // ---- single read from client 0 ----
    c0_rd = 1'b1; c0_lba = 32'h1234; c0_drive = 1'b0;
    tick();                                   // t+1
    c0_rd = 1'b0;
    check("rd_busy_t1", c0_busy, 1'b1);
    check("rd_sd_rd_t1", bus.sd_rd, 2'b00);
    tick();                                   // t+2
    check("rd_sd_rd_t2", bus.sd_rd, 2'b01);
    check("rd_sd_wr_t2", bus.sd_wr, 2'b00);
    check("rd_sd_lba",   bus.sd_lba, 32'h1234);
    bus.sd_ack = 1'b1;                        // rise at a
    tick();                                   // a+1
    check("rd_req_drop", bus.sd_rd, 2'b00);
    check("rd_no_early_done", c0_done, 1'b0);
    tick(); tick();
    bus.sd_ack = 1'b0;                        // fall at f
    tick();                                   // f+1
    check("rd_done", c0_done, 1'b1);
    check("rd_err",  c0_err,  1'b0);
    check("rd_busy_in_done", c0_busy, 1'b1);
    tick();                                   // f+2
    check("rd_done_pulse", c0_done, 1'b0);
    check("rd_busy_clear", c0_busy, 1'b0);

    // ---- tie with last_g = 0: client 1 first, 512 dout strobes ----
    c0_wr = 1'b1; c0_lba = 32'h300; c0_drive = 1'b0;
    c1_rd = 1'b1; c1_lba = 32'h400; c1_drive = 1'b1;
    tick();
    c0_wr = 1'b0; c1_rd = 1'b0;
    check("tie1_busy", {c1_busy, c0_busy}, 2'b11);
    tick();
    check("tie1_sd_rd",  bus.sd_rd,  2'b10);
    check("tie1_sd_wr",  bus.sd_wr,  2'b00);
    check("tie1_sd_lba", bus.sd_lba, 32'h400);
    bus.sd_ack = 1'b1;
    tick();
    for (int i = 0; i < 512; i++) begin
      bus.sd_dout_strobe = 1'b1;
      tick();
      bus.sd_dout_strobe = 1'b0;
      tick();
    end
    bus.sd_ack = 1'b0;
    tick();
    check("tie1_c1_done", {c1_done, c0_done}, 2'b10);
    check("dout_cnt_c1", c1_dout_cnt, 32'd512);
    check("dout_cnt_c0", c0_dout_cnt, 32'd0);
    tick();                                   // f+2
    check("tie1_busy_after", {c1_busy, c0_busy}, 2'b01);
    check("tie1_idle_gap", bus.sd_wr, 2'b00);
    tick();                                   // f+3
    check("tie1_c0_sd_wr", bus.sd_wr, 2'b01);
    check("tie1_c0_lba",   bus.sd_lba, 32'h300);
    bus.sd_ack = 1'b1;
    tick();
    bus.sd_ack = 1'b0;
    tick();
    check("tie1_c0_done", {c1_done, c0_done, c0_err}, 3'b010);
    tick();

    // ---- reset during XFER ----
    c1_rd = 1'b1; c1_lba = 32'h55; c1_drive = 1'b1;
    tick();
    c1_rd = 1'b0;
    tick();
    check("rx_sd_rd", bus.sd_rd, 2'b10);
    bus.sd_ack = 1'b1;
    tick();                                   // XFER
    reset = 1'b1;
    tick();
    check("rx_sd_rdwr", {bus.sd_rd, bus.sd_wr}, 4'b0000);
    check("rx_busy", {c1_busy, c0_busy}, 2'b00);
    check("rx_no_done", {c1_done, c0_done}, 2'b00);
    reset = 1'b0; bus.sd_ack = 1'b0;
    tick();
    check("rx_no_done_later", {c1_done, c0_done}, 2'b00);

    // ---- tie after reset: client 0 first, write data routing ----
    c0_wr = 1'b1; c0_lba = 32'h100; c0_drive = 1'b1; c0_din = 8'hA5;
    c1_rd = 1'b1; c1_lba = 32'h200; c1_drive = 1'b1; c1_din = 8'h3C;
    tick();
    c0_wr = 1'b0; c1_rd = 1'b0;
    bus.sd_din_strobe = 1'b1;
    check("din_idle", bus.sd_din, 8'h00);
    check("din_strobe_idle", {c1_din_strobe, c0_din_strobe}, 2'b00);
    tick();                                   // ISSUE for client 0
    check("tie2_sd_wr",  bus.sd_wr,  2'b10);
    check("tie2_sd_rd",  bus.sd_rd,  2'b00);
    check("tie2_sd_lba", bus.sd_lba, 32'h100);
    check("din_issue", bus.sd_din, 8'hA5);
    check("din_strobe_issue", {c1_din_strobe, c0_din_strobe}, 2'b01);
    bus.sd_ack = 1'b1;
    tick();                                   // XFER
    check("tie2_wr_drop", bus.sd_wr, 2'b00);
    check("din_xfer", bus.sd_din, 8'hA5);
    bus.sd_din_strobe = 1'b0;
    #1;
    check("din_strobe_zero_lat", {c1_din_strobe, c0_din_strobe}, 2'b00);
    bus.sd_ack = 1'b0;
    tick();                                   // DONE
    check("tie2_c0_done", {c1_done, c0_done}, 2'b01);
    check("din_done", bus.sd_din, 8'h00);
    tick();                                   // f+2
    check("tie2_gap", bus.sd_rd, 2'b00);
    tick();                                   // f+3
    check("tie2_c1_sd_rd",  bus.sd_rd,  2'b10);
    check("tie2_c1_sd_lba", bus.sd_lba, 32'h200);
    bus.sd_ack = 1'b1;
    tick();
    bus.sd_ack = 1'b0;
    tick();
    check("tie2_c1_done", {c1_done, c0_done, c1_err}, 3'b100);
    tick();

    // ---- read wins over write in the same pulse ----
    c0_rd = 1'b1; c0_wr = 1'b1; c0_lba = 32'h77; c0_drive = 1'b0;
    tick();
    c0_rd = 1'b0; c0_wr = 1'b0;
    tick();
    check("rdwr_sd_rd", bus.sd_rd, 2'b01);
    check("rdwr_sd_wr", bus.sd_wr, 2'b00);
    // pulse while busy is ignored: lba must stay 0x77 after completion
    c0_wr = 1'b1; c0_lba = 32'h99;
    tick();
    c0_wr = 1'b0;
    check("busy_ignore_lba", bus.sd_lba, 32'h77);
    bus.sd_ack = 1'b1;
    tick();
    bus.sd_ack = 1'b0;
    tick();
    tick();                                   // f+2
    check("busy_ignore_idle", c0_busy, 1'b0);
    tick();
    check("busy_ignore_no_issue", {bus.sd_rd, bus.sd_wr}, 4'b0000);

`ifdef SD_ARB_TIMEOUT_EN
    // ---- timeout: sd_ack never rises ----
    c0_rd = 1'b1; c0_lba = 32'hABC; c0_drive = 1'b0;
    tick();
    c0_rd = 1'b0;
    tick();                                   // issue cycle i
    check("tmo_issue", bus.sd_rd, 2'b01);
    repeat (99) tick();                       // i+99
    check("tmo_still_req", bus.sd_rd, 2'b01);
    tick();                                   // i+100
    check("tmo_drop", bus.sd_rd, 2'b00);
    check("tmo_done_err", {c0_done, c0_err}, 2'b11);
    tick();
    check("tmo_idle", c0_busy, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
